// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and block-geometry constants for the cache fill controller.
// The STORE state exists only when CACHE_FILL_STORE_PORT_EN is defined.
package cache_pkg;

`ifdef CACHE_FILL_STORE_PORT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STORE = 2'd2} fill_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1} fill_state_t;
`endif

  typedef enum logic {SEL_I = 1'b0, SEL_D = 1'b1} sel_t;

  localparam int BLOCK_WORDS = 8;
  localparam int WORD_IDX_W  = 3;
  // 8 words of 2 bytes: the block offset spans 4 byte-address bits
  localparam int BLOCK_OFF_W = 4;

endpackage

// File: rtl/cache_fill_ctrl_beat_counter.sv
// Block-beat counter: clear wins over increment; wrap_o flags the increment
// that rolls the last word index back to zero.
module beat_counter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  inc_i,
  output logic [WORD_IDX_W-1:0] cnt_o,
  output logic                  wrap_o
);

  logic [WORD_IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = inc_i && (cnt_q == '1);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Block-fill responder for the split I/D caches; serialises the memory port.
// Optional write-through store port: CACHE_FILL_STORE_PORT_EN.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CACHE_FILL_STORE_PORT_EN
  input  logic                  st_req,
  input  logic [ADDR_W-1:0]     st_addr,
  input  logic [DATA_W-1:0]     st_data,
  output logic                  st_ack,
`endif
  input  logic                  d_miss,
  input  logic [ADDR_W-1:0]     d_miss_addr,
  input  logic                  i_miss,
  input  logic [ADDR_W-1:0]     i_miss_addr,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     mem_data_out,
  input  logic                  mem_data_valid,
  output logic                  fill_we_d,
  output logic                  fill_we_i,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic [DATA_W-1:0]     fill_data,
  output logic                  tag_we_d,
  output logic                  tag_we_i,
  output logic                  d_fill_done,
  output logic                  i_fill_done,
  output logic                  busy
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << BLOCK_OFF_W) - 1);

  // The controller only counts returned beats, so any latency works as long
  // as the memory keeps request order.
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("cache_fill_ctrl: MEM_LAT must be at least 1");
  end

  fill_state_t           state_q, state_d;
  sel_t                  sel_q, sel_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic                  issued_q, issued_d;

  logic                  start_fill;
  logic                  issue_inc, issue_wrap;
  logic                  recv_inc, recv_wrap;
  logic [WORD_IDX_W-1:0] issue_cnt, recv_cnt;
  logic                  arb, mask_d, mask_i;
`ifdef CACHE_FILL_STORE_PORT_EN
  logic                  mask_st;
`endif

  assign issue_inc = (state_q == FILL) && !issued_q;
  assign recv_inc  = (state_q == FILL) && mem_data_valid;

  beat_counter u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_fill),
    .inc_i  (issue_inc),
    .cnt_o  (issue_cnt),
    .wrap_o (issue_wrap)
  );

  beat_counter u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_fill),
    .inc_i  (recv_inc),
    .cnt_o  (recv_cnt),
    .wrap_o (recv_wrap)
  );

  // Arbitration runs in IDLE and again on the cycle a transaction ends, with
  // the requester just served masked out (its level request is still high
  // that cycle). This lets a waiting miss issue right after a fill.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    base_d     = base_q;
    issued_d   = issued_q;
    start_fill = 1'b0;
    arb        = 1'b0;
    mask_d     = 1'b0;
    mask_i     = 1'b0;
`ifdef CACHE_FILL_STORE_PORT_EN
    mask_st    = 1'b0;
`endif
    case (state_q)
      IDLE: arb = 1'b1;
      FILL: begin
        if (issue_wrap) issued_d = 1'b1;
        if (recv_wrap) begin
          state_d = IDLE;
          arb     = 1'b1;
          mask_d  = (sel_q == SEL_D);
          mask_i  = (sel_q == SEL_I);
        end
      end
`ifdef CACHE_FILL_STORE_PORT_EN
      STORE: begin
        state_d = IDLE;
        arb     = 1'b1;
        mask_st = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (arb) begin
      if (d_miss && !mask_d) begin
        state_d    = FILL;
        sel_d      = SEL_D;
        base_d     = d_miss_addr & ~OFF_MASK;
        start_fill = 1'b1;
      end
`ifdef CACHE_FILL_STORE_PORT_EN
      else if (st_req && !mask_st) begin
        state_d = STORE;
      end
`endif
      else if (i_miss && !mask_i) begin
        state_d    = FILL;
        sel_d      = SEL_I;
        base_d     = i_miss_addr & ~OFF_MASK;
        start_fill = 1'b1;
      end
    end

    if (start_fill) issued_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= SEL_I;
      base_q   <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      base_q   <= base_d;
      issued_q <= issued_d;
    end
  end

  // Request side is a pure state decode; fill strobes follow mem_data_valid.
  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    fill_we_d   = 1'b0;
    fill_we_i   = 1'b0;
    fill_word   = '0;
    fill_data   = '0;
    tag_we_d    = 1'b0;
    tag_we_i    = 1'b0;
    d_fill_done = 1'b0;
    i_fill_done = 1'b0;
`ifdef CACHE_FILL_STORE_PORT_EN
    st_ack      = 1'b0;
`endif
    busy        = (state_q != IDLE);

    if (state_q == FILL) begin
      mem_addr = base_q | ADDR_W'({issue_cnt, 1'b0});
      if (!issued_q) mem_enable = 1'b1;
      if (mem_data_valid) begin
        fill_we_d = (sel_q == SEL_D);
        fill_we_i = (sel_q == SEL_I);
        fill_word = recv_cnt;
        fill_data = mem_data_out;
        if (recv_wrap) begin
          tag_we_d    = (sel_q == SEL_D);
          tag_we_i    = (sel_q == SEL_I);
          d_fill_done = (sel_q == SEL_D);
          i_fill_done = (sel_q == SEL_I);
        end
      end
    end
`ifdef CACHE_FILL_STORE_PORT_EN
    if (state_q == STORE) begin
      mem_enable  = 1'b1;
      mem_wr      = 1'b1;
      mem_addr    = st_addr;
      mem_data_in = st_data;
      st_ack      = 1'b1;
    end
`endif
  end

endmodule
